// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared types and sizing helpers for the floating-point multiply path
package fpmul_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: operand and product valid/ready handshakes of the multiplier
interface shift_add_mult_if #(parameter int WIDTH = 24);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic [2*WIDTH-1:0] p;
   modport master (output in_valid, x, y, out_ready, input in_ready, out_valid, p);
   modport slave (input in_valid, x, y, out_ready, output in_ready, out_valid, p);
endinterface

// File: rtl/shift_add_mult_adder_w.sv
// adder_w: parametrised WIDTH-bit adder with carry-in and carry-out
module adder_w #(parameter int WIDTH = 24) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential shift-and-add unsigned multiplier, one multiplier bit retired per cycle
module shift_add_mult
   import fpmul_pkg::*;
#(parameter int WIDTH = 24) (
   input logic             clk,
   input logic             rst,
   shift_add_mult_if.slave bus
);
   localparam int CW = cnt_w(WIDTH);
   state_t state, state_n;
   logic [WIDTH-1:0] a, lo, s;
   logic [WIDTH-2:0] hr;
   logic [CW-1:0] count;
   logic carry, c, accept;
   // Hi is held as {carry, hr}: the adder carry-out lands in Hi's top bit on every shift
   adder_w #(.WIDTH(WIDTH)) u_add (
      .a  ({carry, hr}),
      .b  (lo[0] ? a : '0),
      .ci (1'b0),
      .s  (s),
      .co (c)
   );
   always_comb begin
      bus.in_ready = 1'b0;
      bus.out_valid = 1'b0;
      state_n = state;
      bus.in_ready = !rst && (state == IDLE || (state == DONE && bus.out_ready));
      bus.out_valid = state == DONE;
      accept = bus.in_valid && bus.in_ready;
      state_n = state == IDLE ? (accept ? RUN : IDLE) :
                state == RUN  ? (count == CW'(1) ? DONE : RUN) :
                !bus.out_ready ? DONE : accept ? RUN : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a <= '0;
         lo <= '0;
         hr <= '0;
         carry <= 1'b0;
         count <= '0;
         bus.p <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            a <= bus.x;
            lo <= bus.y;
            {carry, hr} <= '0;
            count <= CW'(WIDTH);
         end else if (state == RUN) begin
            {carry, hr} <= {c, s[WIDTH-1:1]};
            lo <= {s[0], lo[WIDTH-1:1]};
            count <= count - CW'(1);
            if (count == CW'(1)) bus.p <= {c, s, lo[WIDTH-1:1]};
         end
      end
   end
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: scoreboard bench for the shift-and-add multiplier at WIDTH=24 and WIDTH=8
module tb_shift_add_mult;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   shift_add_mult_if #(.WIDTH(24)) b24();
   shift_add_mult_if #(.WIDTH(8))  b8();
   shift_add_mult #(.WIDTH(24)) dut24 (.clk(clk), .rst(rst), .bus(b24));
   shift_add_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc24 = 0;
   int last8 = -1;
   bit stream8 = 1'b0;
   logic [63:0] q24[$];
   logic [63:0] q8[$];
   logic [23:0] cx[4] = '{24'h800000, 24'h123456, 24'h123456, 24'h000001};
   logic [23:0] cy[4] = '{24'h800000, 24'h000000, 24'h000001, 24'hFFFFFF};
   logic [7:0]  sx[5] = '{8'hFF, 8'h00, 8'hFF, 8'h01, 8'h80};
   logic [7:0]  sy[5] = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h80};
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (b24.out_valid && b24.out_ready) begin
         if (q24.size() == 0) chk("p24_spurious", 64'(b24.out_valid), 64'd0);
         else chk("p24", 64'(b24.p), q24.pop_front());
      end
      if (b8.out_valid && b8.out_ready) begin
         if (q8.size() == 0) chk("p8_spurious", 64'(b8.out_valid), 64'd0);
         else chk("p8", 64'(b8.p), q8.pop_front());
         if (stream8 && last8 >= 0) chk("gap8", 64'(cyc - last8), 64'd9);
         last8 = cyc;
      end
   end
   task automatic send24(input logic [23:0] x, input logic [23:0] y);
      bit ok = 1'b0;
      b24.x = x;
      b24.y = y;
      b24.in_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (b24.in_ready) begin
            ok = 1'b1;
            acc24 = cyc;
            q24.push_back(64'(x) * 64'(y));
         end
      end
      if (!ok) chk("acc24_timeout", 64'(b24.in_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask
   task automatic send8(input logic [7:0] x, input logic [7:0] y);
      bit ok = 1'b0;
      b8.x = x;
      b8.y = y;
      b8.in_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (b8.in_ready) begin
            ok = 1'b1;
            q8.push_back(64'(x) * 64'(y));
         end
      end
      if (!ok) chk("acc8_timeout", 64'(b8.in_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask
   task automatic wait_ov24();
      for (int k = 0; k < 100 && !b24.out_valid; k++) @(negedge clk);
      if (!b24.out_valid) chk("ov24_timeout", 64'(b24.out_valid), 64'd1);
   endtask
   task automatic drain24();
      for (int k = 0; k < 200 && q24.size() != 0; k++) @(negedge clk);
      chk("drain24", 64'(q24.size()), 64'd0);
   endtask
   task automatic drain8();
      for (int k = 0; k < 200 && q8.size() != 0; k++) @(negedge clk);
      chk("drain8", 64'(q8.size()), 64'd0);
   endtask
   initial begin
      logic [63:0] bp;
      int c0;
      b24.in_valid = 1'b0; b24.x = '0; b24.y = '0; b24.out_ready = 1'b1;
      b8.in_valid = 1'b0;  b8.x = '0;  b8.y = '0;  b8.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready24", 64'(b24.in_ready), 64'd0);
      chk("rst_out_valid24", 64'(b24.out_valid), 64'd0);
      chk("rst_p24", 64'(b24.p), 64'd0);
      chk("rst_in_ready8", 64'(b8.in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(b24.in_ready), 64'd1);
      @(posedge clk);
      #1;
      send24(24'hFFFFFF, 24'hFFFFFF);
      b24.in_valid = 1'b0;
      wait_ov24();
      chk("lat24", 64'(cyc - acc24 - 1), 64'd24);
      chk("p_max", 64'(b24.p), 64'hFFFFFE000001);
      @(negedge clk);
      chk("pulse24", 64'(b24.out_valid), 64'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         send24(cx[i], cy[i]);
         b24.in_valid = 1'b0;
         drain24();
         @(posedge clk);
         #1;
      end
      b24.out_ready = 1'b0;
      bp = 64'(24'hABCDEF) * 64'(24'h13579B);
      send24(24'hABCDEF, 24'h13579B);
      b24.in_valid = 1'b0;
      wait_ov24();
      repeat (5) begin
         chk("bp_p", 64'(b24.p), bp);
         chk("bp_ov", 64'(b24.out_valid), 64'd1);
         chk("bp_in_ready", 64'(b24.in_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      b24.out_ready = 1'b1;
      c0 = cyc;
      send24(24'h000777, 24'h000999);
      chk("bp_same_cycle_accept", 64'(acc24), 64'(c0));
      b24.in_valid = 1'b0;
      drain24();
      @(posedge clk);
      #1;
      send24(24'h00A5A5, 24'h005A5A);
      b24.in_valid = 1'b0;
      repeat (30) begin
         b24.x = 24'($urandom);
         b24.y = 24'($urandom);
         @(posedge clk);
         #1;
      end
      drain24();
      @(posedge clk);
      #1;
      send24(24'h0F0F0F, 24'h00FFFF);
      b24.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("in_ready_in_rst", 64'(b24.in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      void'(q24.pop_back());
      @(negedge clk);
      chk("abort_p", 64'(b24.p), 64'd0);
      chk("abort_ov", 64'(b24.out_valid), 64'd0);
      chk("abort_in_ready", 64'(b24.in_ready), 64'd1);
      repeat (30) @(negedge clk);
      chk("abort_no_ov", 64'(b24.out_valid), 64'd0);
      @(posedge clk);
      #1;
      send24(24'h000003, 24'h000005);
      b24.in_valid = 1'b0;
      drain24();
      chk("p_3x5", 64'(b24.p), 64'h00000000000F);
      @(posedge clk);
      #1;
      stream8 = 1'b1;
      for (int i = 0; i < 5; i++) send8(sx[i], sy[i]);
      for (int i = 0; i < 1500; i++) send8(8'($urandom), 8'($urandom));
      b8.in_valid = 1'b0;
      drain8();
      stream8 = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
